data_memory: RTL and testbench

- Word-organised data memory for the CPU datapath, serving load/store accesses from the execute/memory stage.
- Storage is 16-bit words with byte addresses.
- Write is synchronous; read is combinational and gated by a read enable.
- Contents clear on an asynchronous active-low reset.

---
 rtl/data_memory.sv | 45 ++++
 tb/tb_data_memory.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-organised 16-bit data memory with byte addressing.
// Synchronous write, gated combinational read, async active-low clear.
module data_memory #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rEnable,
   input  logic        wEnable,
   input  logic [15:0] address,
   input  logic [15:0] wData,
   output logic [15:0] rData
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] w_idx;
   logic          w_in_range;
   logic          w_unused_lsb;

   assign w_idx        = address[AW:1];
   assign w_unused_lsb = address[0];

   // Shift form stays legal even when AW+1 reaches the address width.
   assign w_in_range = ((address >> (AW + 1)) == 16'h0000);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 16'h0000;
         end
      end else if (wEnable && w_in_range) begin
         r_mem[w_idx] <= wData;
      end
   end

   always_comb begin
      rData = 16'h0000;
      if (rst && rEnable && w_in_range) begin
         rData = r_mem[w_idx];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Inputs change on negedge; outputs sampled away from posedge.
module tb_data_memory;

   logic        clk;
   logic        rst;
   logic        rEnable;
   logic        wEnable;
   logic [15:0] address;
   logic [15:0] wData;
   logic [15:0] rData;

   int n_checks;
   int n_errors;

   data_memory #(.DEPTH(256)) dut (
      .clk     (clk),
      .rst     (rst),
      .rEnable (rEnable),
      .wEnable (wEnable),
      .address (address),
      .wData   (wData),
      .rData   (rData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      address = a;
      wData   = d;
      wEnable = 1'b1;
      @(posedge clk);
      #1;
      wEnable = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a,
                     input logic [15:0] exp);
      address = a;
      #1;
      check(tag, rData, exp);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b0;
      rEnable  = 1'b1;
      wEnable  = 1'b1;
      address  = 16'h0000;
      wData    = 16'h5A5A;
      #10;
      check("rst_hold_rdata", rData, 16'h0000);
      @(negedge clk);
      wEnable = 1'b0;
      rst     = 1'b1;
      rd("post_rst_0000", 16'h0000, 16'h0000);
      rd("post_rst_0002", 16'h0002, 16'h0000);
      rd("post_rst_0004", 16'h0004, 16'h0000);
      rd("post_rst_0006", 16'h0006, 16'h0000);
      rd("post_rst_0008", 16'h0008, 16'h0000);

      @(negedge clk);
      address = 16'h0000;
      wData   = 16'hAAAA;
      wEnable = 1'b1;
      #1;
      check("pre_edge_old", rData, 16'h0000);
      @(posedge clk);
      #1;
      check("post_edge_new", rData, 16'hAAAA);
      wEnable = 1'b0;
      rd("other_word", 16'h0002, 16'h0000);
      rd("odd_alias", 16'h0001, 16'hAAAA);
      rEnable = 1'b0;
      rd("ren_off_0000", 16'h0000, 16'h0000);
      rd("ren_off_0001", 16'h0001, 16'h0000);
      rEnable = 1'b1;

      wr(16'h01FE, 16'h1234);
      rd("top_word", 16'h01FE, 16'h1234);
      rd("top_word_odd", 16'h01FF, 16'h1234);
      wr(16'h1010, 16'h1111);
      rd("oor_read_1010", 16'h1010, 16'h0000);
      rd("oor_no_alias", 16'h0010, 16'h0000);
      wr(16'h0200, 16'h2222);
      rd("oor_0200", 16'h0200, 16'h0000);
      rd("oor_no_wrap", 16'h0000, 16'hAAAA);
      wr(16'h000A, 16'hBEEF);
      wr(16'h000C, 16'hC0DE);
      rd("indep_000a", 16'h000A, 16'hBEEF);
      rd("indep_000c", 16'h000C, 16'hC0DE);
      wr(16'h000A, 16'h0F0F);
      rd("overwrite_000a", 16'h000A, 16'h0F0F);

      @(negedge clk);
      address = 16'h0000;
      #1;
      check("pre_async_rst", rData, 16'hAAAA);
      #1;
      rst = 1'b0;
      #1;
      check("async_rst_now", rData, 16'h0000);
      wEnable = 1'b1;
      wData   = 16'h5555;
      @(posedge clk);
      #1;
      check("rst_blocks_wr", rData, 16'h0000);
      @(negedge clk);
      wEnable = 1'b0;
      rst     = 1'b1;
      rd("after_rst_0000", 16'h0000, 16'h0000);
      rd("after_rst_01fe", 16'h01FE, 16'h0000);
      rd("after_rst_000a", 16'h000A, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
